// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package slc3_mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Word address that maps to the switches (read) and the hex display (write)
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    // Default access latencies in cycles, legal range 1..15
    localparam int DEFAULT_READ_LAT  = 2;
    localparam int DEFAULT_WRITE_LAT = 2;

endpackage

// File: rtl/slc3_mem_array.sv
// Single-port synchronous RAM, 2^ADDR_W words, registered read data.
// Contents are never cleared; reset does not touch the array.
module slc3_mem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // One access port: optional write plus a registered read every cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: fixed-latency read/write handshake in front of a
// synchronous RAM, with a memory-mapped switch input and hex display register.
// A request is latched in IDLE, counted down in READ/WRITE, acknowledged by a
// one-cycle R pulse, and then parked in HOLD until the requester lets go of
// OE and WE so the same request cannot be executed twice.
module slc3_mem_responder
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = DEFAULT_READ_LAT,
    parameter int WRITE_LAT = DEFAULT_WRITE_LAT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_SRAM,
    input  logic        OE,
    input  logic        WE,
    input  logic [9:0]  SW,
    output logic [15:0] Data_from_SRAM,
    output logic        R,
    output logic [15:0] HEX_REG,
    output logic        ERR
);

    localparam logic [3:0] RD_LOAD = 4'(READ_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LAT - 1);

    state_t            state;
    state_t            next_state;
    logic [3:0]        cnt;
    logic [15:0]       addr_q;
    logic [15:0]       wdata_q;

    logic              accept_rd;
    logic              accept_wr;
    logic              overlap;
    logic              busy;
    logic              done;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_rdata;

    // True when the word address falls inside the backing RAM
    function automatic logic in_ram(input logic [15:0] a);
        return (a >> ADDR_W) == 16'd0;
    endfunction

    // Value a completing read returns for the latched address
    function automatic logic [15:0] read_value(input logic [15:0] a,
                                               input logic [9:0]  sw,
                                               input logic [15:0] ram);
        if (a == IO_ADDR) begin
            return {6'b0, sw};
        end else if (in_ram(a)) begin
            return ram;
        end else begin
            return 16'h0000;
        end
    endfunction

    slc3_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) u_array (
        .clk   (Clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // State register; reset wins over any request presented at the same edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (OE && !WE) begin
                    next_state = READ;
                end else if (WE && !OE) begin
                    next_state = WRITE;
                end
            end
            READ, WRITE: begin
                if (cnt == 4'd0) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (!OE && !WE) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Control decode; the RAM is addressed straight from ADDR while idle so a
    // single-cycle read has its data registered by the completion edge
    always_comb begin
        busy      = (state == READ) || (state == WRITE);
        accept_rd = (state == IDLE) && OE && !WE;
        accept_wr = (state == IDLE) && WE && !OE;
        overlap   = (state == IDLE) && OE && WE;
        done      = busy && (cnt == 4'd0);
        ram_we    = (state == WRITE) && (cnt == 4'd0) && !Reset
                    && (addr_q != IO_ADDR) && in_ram(addr_q);
        ram_addr  = (state == IDLE) ? ADDR[ADDR_W-1:0] : addr_q[ADDR_W-1:0];
    end

    // Counter, ready pulse, read data, display register and error flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt            <= 4'd0;
            R              <= 1'b0;
            Data_from_SRAM <= 16'h0000;
            HEX_REG        <= 16'h0000;
            ERR            <= 1'b0;
        end else begin
            R <= done;
            if (accept_rd) begin
                cnt <= RD_LOAD;
            end else if (accept_wr) begin
                cnt <= WR_LOAD;
            end else if (busy && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (overlap) begin
                ERR <= 1'b1;
            end
            if (done && state == READ) begin
                Data_from_SRAM <= read_value(addr_q, SW, ram_rdata);
            end
            if (done && state == WRITE && addr_q == IO_ADDR) begin
                HEX_REG <= wdata_q;
            end
        end
    end

    // Request capture; contents only matter after an accepted request
    always_ff @(posedge Clk) begin
        if (accept_rd || accept_wr) begin
            addr_q <= ADDR;
        end
        if (accept_wr) begin
            wdata_q <= Data_to_SRAM;
        end
    end

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Self-checking bench for slc3_mem_responder with a response scoreboard.
module tb_slc3_mem_responder;

    localparam int AW     = 10;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        OE;
    logic        WE;
    logic [9:0]  SW;
    logic [15:0] Data_from_SRAM;
    logic        R;
    logic [15:0] HEX_REG;
    logic        ERR;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [15:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] model_mem [int];
    logic [15:0] model_hex;
    logic [15:0] last_read;

    slc3_mem_responder #(
        .ADDR_W    (AW),
        .READ_LAT  (RD_LAT),
        .WRITE_LAT (WR_LAT)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .OE             (OE),
        .WE             (WE),
        .SW             (SW),
        .Data_from_SRAM (Data_from_SRAM),
        .R              (R),
        .HEX_REG        (HEX_REG),
        .ERR            (ERR)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Every R pulse must match the oldest outstanding expected response
    always @(negedge Clk) begin
        if (R === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_R cyc=%0d data=%h", cyc, Data_from_SRAM);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.cyc || Data_from_SRAM !== e.data) begin
                    errors++;
                    $display("FAIL response addr=%h got cyc=%0d data=%h expected cyc=%0d data=%h",
                             e.addr, cyc, Data_from_SRAM, e.cyc, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // One complete access: predict the response, wait for R, then release
    task automatic access(input logic is_wr, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        bit   got;
        int   lat;
        @(negedge Clk);
        ADDR         = a;
        Data_to_SRAM = d;
        OE           = !is_wr;
        WE           = is_wr;
        lat          = is_wr ? WR_LAT : RD_LAT;
        if (is_wr) begin
            if (a == 16'hFFFF) model_hex = d;
            else if (a < (1 << AW)) model_mem[int'(a)] = d;
        end else begin
            if (a == 16'hFFFF) last_read = {6'b0, SW};
            else if (a < (1 << AW)) last_read = model_mem[int'(a)];
            else last_read = 16'h0000;
        end
        e.cyc  = cyc + 1 + lat;
        e.data = last_read;
        e.addr = a;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clk);
            if (R === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ready_timeout addr=%h got no R expected R within 20 cycles", a);
        end
        OE = 1'b0;
        WE = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; OE = 1'b1; WE = 1'b1; ADDR = 16'h0000;
        Data_to_SRAM = 16'h0000; SW = 10'h000;
        model_hex = 16'h0000; last_read = 16'h0000;
        repeat (3) @(negedge Clk);
        checks++; if (Data_from_SRAM !== 16'h0000) begin errors++; $display("FAIL reset_data got %h expected 0000", Data_from_SRAM); end
        checks++; if (R !== 1'b0) begin errors++; $display("FAIL reset_R got %b expected 0", R); end
        checks++; if (HEX_REG !== 16'h0000) begin errors++; $display("FAIL reset_hex got %h expected 0000", HEX_REG); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", ERR); end
        OE = 1'b0; WE = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_priority_err got %b expected 0", ERR); end
    endtask

    task automatic test_write_read();
        access(1'b1, 16'h0005, 16'hBEEF);
        access(1'b0, 16'h0005, 16'h0000);
        checks++; if (Data_from_SRAM !== 16'hBEEF) begin errors++; $display("FAIL read_back got %h expected beef", Data_from_SRAM); end
    endtask

    task automatic test_io();
        SW = 10'h2A5;
        access(1'b1, 16'h03FF, 16'hCAFE);
        access(1'b0, 16'hFFFF, 16'h0000);
        access(1'b1, 16'hFFFF, 16'h1234);
        checks++; if (HEX_REG !== model_hex) begin errors++; $display("FAIL hex_write got %h expected %h", HEX_REG, model_hex); end
        checks++; if (Data_from_SRAM !== 16'h02A5) begin errors++; $display("FAIL data_hold got %h expected 02a5", Data_from_SRAM); end
        access(1'b0, 16'h03FF, 16'h0000);
    endtask

    task automatic test_hold();
        exp_t e;
        access(1'b1, 16'h0010, 16'hAAAA);
        access(1'b1, 16'h0011, 16'h5555);
        @(negedge Clk);
        ADDR = 16'h0010; OE = 1'b1; WE = 1'b0;
        last_read = model_mem[16];
        e.cyc = cyc + 1 + RD_LAT; e.data = last_read; e.addr = 16'h0010;
        sb.push_back(e);
        @(negedge Clk);
        ADDR = 16'h0011; WE = 1'b1;
        repeat (8) @(negedge Clk);
        OE = 1'b0; WE = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL hold_response got %0d pending expected 0", sb.size()); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL overlap_outside_idle got ERR=%b expected 0", ERR); end
        checks++; if (Data_from_SRAM !== 16'hAAAA) begin errors++; $display("FAIL hold_addr got %h expected aaaa", Data_from_SRAM); end
    endtask

    task automatic test_error();
        @(negedge Clk);
        ADDR = 16'h0005; Data_to_SRAM = 16'hDEAD; OE = 1'b1; WE = 1'b1;
        @(negedge Clk);
        OE = 1'b0; WE = 1'b0;
        repeat (4) @(negedge Clk);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_set got %b expected 1", ERR); end
        access(1'b0, 16'h0005, 16'h0000);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", ERR); end
    endtask

    task automatic test_abort();
        access(1'b1, 16'h0007, 16'h7777);
        // reset one edge after acceptance
        @(negedge Clk);
        ADDR = 16'h0007; Data_to_SRAM = 16'h0BAD; WE = 1'b1;
        @(negedge Clk);
        Reset = 1'b1; WE = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        model_hex = 16'h0000; last_read = 16'h0000;
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", ERR); end
        checks++; if (Data_from_SRAM !== 16'h0000) begin errors++; $display("FAIL abort_data got %h expected 0000", Data_from_SRAM); end
        // reset on the completion edge itself
        @(negedge Clk);
        ADDR = 16'h0007; Data_to_SRAM = 16'h0BAD; WE = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b1; WE = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        checks++; if (R !== 1'b0) begin errors++; $display("FAIL abort_R got %b expected 0", R); end
        access(1'b0, 16'h0007, 16'h0000);
        checks++; if (Data_from_SRAM !== 16'h7777) begin errors++; $display("FAIL abort_ram got %h expected 7777", Data_from_SRAM); end
    endtask

    task automatic test_range();
        access(1'b1, 16'h0000, 16'h1111);
        access(1'b1, 16'h0400, 16'h2222);
        access(1'b0, 16'h0400, 16'h0000);
        checks++; if (Data_from_SRAM !== 16'h0000) begin errors++; $display("FAIL range_read got %h expected 0000", Data_from_SRAM); end
        access(1'b0, 16'h0000, 16'h0000);
        access(1'b0, 16'hFFFE, 16'h0000);
        access(1'b0, 16'h0000, 16'h0000);
        checks++; if (Data_from_SRAM !== 16'h1111) begin errors++; $display("FAIL range_write got %h expected 1111", Data_from_SRAM); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_io();
        test_hold();
        test_error();
        test_abort();
        test_range();
        repeat (3) @(negedge Clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_responses got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slc3_mem_responder.md
SLC3_MEM_RESPONDER -- requirements
Module: slc3_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width of the backing RAM (2^ADDR_W 16-bit words).
REQ-002 Parameter READ_LAT, default 2: cycles from request acceptance to read-ready; legal range 1..15.
REQ-003 Parameter WRITE_LAT, default 2: cycles from request acceptance to write-ready; legal range 1..15.
REQ-004 Clk  in  1  single clock; all state SHALL change on the rising edge only.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 ADDR  in  16  requester word address.
REQ-007 Data_to_SRAM  in  16  write data from the requester.
REQ-008 OE  in  1  active-high read request.
REQ-009 WE  in  1  active-high write request.
REQ-010 SW  in  10  switch inputs, mapped at the I/O address.
REQ-011 Data_from_SRAM  out  16  registered read data.
REQ-012 R  out  1  ready; a one-cycle pulse per completed access.
REQ-013 HEX_REG  out  16  display register, mapped at the I/O address.
REQ-014 ERR  out  1  sticky protocol-error flag.

Function
REQ-015 States SHALL be IDLE, READ, WRITE and HOLD.
REQ-016 IDLE: OE=1 and WE=0 at an edge SHALL latch ADDR, load the counter with READ_LAT-1, and go to READ.
REQ-017 IDLE: WE=1 and OE=0 at an edge SHALL latch ADDR and Data_to_SRAM, load the counter with WRITE_LAT-1, and go to WRITE.
REQ-018 IDLE: OE=1 and WE=1 at an edge SHALL set ERR, perform no access, and remain in IDLE.
REQ-019 READ/WRITE: the counter SHALL decrement each cycle; ADDR, data, OE and WE changes SHALL be ignored until completion.
REQ-020 Completion occurs on the edge where the counter is 0; R SHALL be high for exactly the following cycle, and the FSM SHALL go to HOLD.
REQ-021 Latency: a request accepted at edge k SHALL have R=1 and valid Data_from_SRAM in cycle k+LAT, for LAT = READ_LAT or WRITE_LAT.
REQ-022 Read at latched address 16'hFFFF SHALL return {6'b0, SW} as sampled at completion.
REQ-023 Read at an address below 2^ADDR_W SHALL return the RAM word.
REQ-024 Read at any other address SHALL return 16'h0000 and SHALL still pulse R.
REQ-025 Write at 16'hFFFF SHALL update HEX_REG and leave the RAM unchanged.
REQ-026 Write at an address below 2^ADDR_W SHALL write the RAM.
REQ-027 Write at any other address SHALL be discarded and SHALL still pulse R.
REQ-028 Data_from_SRAM SHALL hold its last read value through writes, HOLD and IDLE until the next read completes.
REQ-029 HOLD: the FSM SHALL return to IDLE only on an edge where OE=0 and WE=0, so a held request is never re-executed.
REQ-030 A request asserted in the same cycle that HOLD exits SHALL NOT be accepted until the next edge seen in IDLE.
REQ-031 ERR SHALL clear only on Reset.
REQ-032 An OE/WE overlap seen outside IDLE SHALL NOT set ERR.

Reset
REQ-033 Reset SHALL force state IDLE, counter 0, Data_from_SRAM 16'h0000, R 0, HEX_REG 16'h0000 and ERR 0.
REQ-034 Reset during READ or WRITE SHALL abort the access: no RAM or HEX_REG update, and no R pulse.
REQ-035 RAM contents SHALL NOT be affected by Reset.
REQ-036 Reset SHALL take priority over every simultaneous request.

Structure
REQ-037 Package slc3_mem_pkg SHALL hold the state enum, the I/O address constant 16'hFFFF, and the default latency constants.
REQ-038 Sub-module slc3_mem_array SHALL be a single-port synchronous RAM (2^ADDR_W x 16) with a write enable and registered read data.
REQ-039 Its read access SHALL be issued one cycle before completion so that REQ-021 holds.
REQ-040 The FSM, counter, address decode and I/O registers SHALL reside in slc3_mem_responder.

Verification
REQ-041 Write test: after Reset, WE=1, ADDR=16'h0005, data 16'hBEEF, then drop WE after R; next, OE=1, ADDR=16'h0005. Required: R at k+2 for each access and Data_from_SRAM=16'hBEEF.
REQ-042 I/O test: SW=10'h2A5, read 16'hFFFF -> Data_from_SRAM=16'h02A5; write 16'h1234 to 16'hFFFF -> HEX_REG=16'h1234, RAM unchanged.
REQ-043 Hold test: OE held high for 10 cycles -> exactly one R pulse; ADDR changed mid-access -> data comes from the originally latched address.
REQ-044 Error test: OE=WE=1 in IDLE -> ERR=1, no R, RAM unchanged; ERR stays 1 until Reset.
REQ-045 Abort and range test: Reset asserted in cycle k+1 of a write to 16'h0007 -> a later read returns the old word, no R. Read of 16'h0400 with ADDR_W=10 -> 16'h0000 with R.
